// File: rtl/garage_door_pkg.sv
`default_nettype none
// ============================================================================
// Module   : garage_door_pkg
// Purpose  : Shared state encodings and motor-command helpers for the
//            garage door controller.
// Revision : 1.0 - initial release
// ============================================================================
package garage_door_pkg;

    // Door controller states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MV_UP = 2'b01,
        ST_MV_DN = 2'b10
    } state_e;

    // Motor drive pair; up and dn are never both set.
    typedef struct packed {
        logic up;
        logic dn;
    } motor_cmd_t;

    // Moore output decode: the motor command is a pure function of state.
    function automatic motor_cmd_t decode_motor(input state_e st);
        motor_cmd_t cmd;
        cmd = '{up: 1'b0, dn: 1'b0};
        case (st)
            ST_MV_UP: cmd.up = 1'b1;
            ST_MV_DN: cmd.dn = 1'b1;
            default:  cmd    = '{up: 1'b0, dn: 1'b0};
        endcase
        return cmd;
    endfunction

endpackage : garage_door_pkg
`default_nettype wire

// File: rtl/garage_door_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : garage_door_fsm_if
// Purpose  : Button / limit-switch inputs and motor outputs of the garage
//            door controller, bundled for connection to the control block.
// Revision : 1.0 - initial release
// ============================================================================
interface garage_door_fsm_if;

    logic Activate;   // momentary door button, level-sampled
    logic UP_Max;     // 1 = door fully open
    logic DN_Max;     // 1 = door fully closed
    logic UP_M;       // 1 = drive motor upward
    logic DN_M;       // 1 = drive motor downward

    // Environment side: drives button and switches, observes the motor.
    modport master (
        output Activate,
        output UP_Max,
        output DN_Max,
        input  UP_M,
        input  DN_M
    );

    // Controller side.
    modport slave (
        input  Activate,
        input  UP_Max,
        input  DN_Max,
        output UP_M,
        output DN_M
    );

endinterface : garage_door_fsm_if
`default_nettype wire

// File: rtl/garage_door_fsm.sv
`default_nettype none
// ============================================================================
// Module   : garage_door_fsm
// Purpose  : Moore FSM driving the garage door motor from the Activate
//            button and the two travel limit switches. Motion starts only
//            from IDLE and stops at the limit in the direction of travel.
// Revision : 1.0 - initial release
// ============================================================================
module garage_door_fsm
    import garage_door_pkg::*;
(
    input  wire logic          CLK,
    input  wire logic          RST,   // asynchronous, active-low
    garage_door_fsm_if.slave   bus
);

    state_e     state_q;
    state_e     state_d;
    logic       up_m_q;
    logic       dn_m_q;
    motor_cmd_t cmd_d;

    // Next-state logic; IDLE decisions follow a fixed priority order.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (!bus.Activate) begin
                    state_d = ST_IDLE;
                end else if (bus.UP_Max && bus.DN_Max) begin
                    // Both limits closed is physically impossible: refuse to move.
                    state_d = ST_IDLE;
                end else if (bus.DN_Max) begin
                    state_d = ST_MV_UP;
                end else begin
                    // Fully open, or stopped mid-travel: closing is the safe default.
                    state_d = ST_MV_DN;
                end
            end
            ST_MV_UP: state_d = bus.UP_Max ? ST_IDLE : ST_MV_UP;
            ST_MV_DN: state_d = bus.DN_Max ? ST_IDLE : ST_MV_DN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Motor command for the state being entered, so the registered outputs
    // always equal the decode of the registered state.
    always_comb begin
        cmd_d = decode_motor(state_d);
    end

    // State and output registers; reset stops the motor without a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            up_m_q  <= 1'b0;
            dn_m_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            up_m_q  <= cmd_d.up;
            dn_m_q  <= cmd_d.dn;
        end
    end

    assign bus.UP_M = up_m_q;
    assign bus.DN_M = dn_m_q;

endmodule : garage_door_fsm
`default_nettype wire

// File: tb/tb_garage_door_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_garage_door_fsm
// Purpose  : Scoreboard bench for garage_door_fsm. The driver pushes the
//            expected motor outputs for each applied vector; a monitor pops
//            and compares after every rising edge or asynchronous-reset probe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_garage_door_fsm;

    typedef struct {
        string name;
        logic  exp_up;
        logic  exp_dn;
    } exp_t;

    logic CLK;
    logic RST;
    int   checks;
    int   passes;
    exp_t sb_q[$];
    event async_ev;

    garage_door_fsm_if bus();

    garage_door_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Compare one expected entry against the current DUT outputs.
    task automatic compare(input exp_t e);
        checks++;
        if (bus.UP_M === e.exp_up && bus.DN_M === e.exp_dn) begin
            passes++;
        end else begin
            $display("FAIL %s: got UP_M=%b DN_M=%b, expected UP_M=%b DN_M=%b",
                     e.name, bus.UP_M, bus.DN_M, e.exp_up, e.exp_dn);
        end
    endtask

    // Monitor: checks pending expectations 1 ns after each edge or probe.
    initial begin
        forever begin
            @(posedge CLK or async_ev);
            #1;
            while (sb_q.size() != 0) begin
                compare(sb_q.pop_front());
            end
        end
    end

    // Apply one vector at the falling edge; the result is due after the next rising edge.
    task automatic step(input logic rst, input logic act, input logic up,
                        input logic dn, input logic eu, input logic ed,
                        input string name);
        @(negedge CLK);
        RST          = rst;
        bus.Activate = act;
        bus.UP_Max   = up;
        bus.DN_Max   = dn;
        sb_q.push_back('{name: name, exp_up: eu, exp_dn: ed});
    endtask

    // Immediate (no clock edge) expectation, used around asynchronous reset.
    task automatic probe_now(input logic eu, input logic ed, input string name);
        sb_q.push_back('{name: name, exp_up: eu, exp_dn: ed});
        ->async_ev;
        #2;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus: rst, Activate, UP_Max, DN_Max -> expected UP_M, DN_M.
    initial begin
        checks       = 0;
        passes       = 0;
        RST          = 1'b0;
        bus.Activate = 1'b0;
        bus.UP_Max   = 1'b0;
        bus.DN_Max   = 1'b1;
        #2;
        probe_now(1'b0, 1'b0, "rst_low");

        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_edge");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "rst_release");

        // Open from closed, then stop at the upper limit.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "open_start");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "open_travel");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "open_limit");

        // Close from open, then stop at the lower limit.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "close_start");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "close_travel");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "close_limit");

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "idle_hold");
        end

        // Activate and DN_Max ignored while moving up.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "ign_start");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "ign_act0");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "ign_act1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ign_act0_mid");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "ign_act1_mid");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ign_limit");

        // Held Activate reverses direction on the next edge; UP_Max ignored moving down.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "held_reverse");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "dn_ignore_up");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "dn_limit");

        // Switch fault: both limits closed keeps the door idle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "fault_idle");
        end

        // Mid-travel start closes the door.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "mid_close");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mv_dn_hold");

        // Asynchronous reset between edges while moving down.
        @(posedge CLK);
        #3;
        RST = 1'b0;
        probe_now(1'b0, 1'b0, "async_rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst_close");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "final_limit");

        // Let the monitor drain, then make sure nothing was left unchecked.
        repeat (2) @(posedge CLK);
        #3;
        if (sb_q.size() != 0) begin
            checks++;
            $display("FAIL sb_drain: got %0d pending entries, expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_garage_door_fsm
`default_nettype wire
